fifo_out_uart_drain: RTL and testbench

Sequencer that empties the TRNG output FIFO (FIFO_OUT) to the board UART transmitter once the CPU has finished a load run. It pops one 32-bit word at a time from the first-word-fall-through FIFO, splits it into four bytes, and hands each byte to the UART TX using a start/busy handshake. It sits in the top level between the FIFO_OUT read port and the UART TX, and is triggered by the top when the loading phase ends.

---
 rtl/trng_io_pkg.sv | 47 ++++
 rtl/fifo_out_uart_drain.sv | 182 ++++++++++++++++++
 tb/tb_fifo_out_uart_drain.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_io_pkg.sv
// Shared TRNG I/O definitions: drain sequencer state codes, CPU memory-map
// addresses for FIFO_OUT and CTRL, and the UART byte width.
// Pure declarations; no clocked logic and no handshakes live here.
package trng_io_pkg;

  // UART transmitter byte width
  localparam int UART_BYTE_W = 8;

  // Drain sequencer state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_SEND      = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_FETCH     = ST_FETCH,
    S_SEND      = ST_SEND,
    S_WAIT_ACK  = ST_WAIT_ACK,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_GAP       = ST_GAP
  } drain_state_e;

  // CPU memory map shared with the firmware
  localparam logic [31:0] CTRL_ADDR     = 32'h4000_0000;
  localparam logic [31:0] FIFO_OUT_ADDR = 32'h4000_0010;

  // Byte idx of a word in transmit order. lsb_first=1 walks [7:0] upward,
  // otherwise [31:24] downward.
  function automatic logic [UART_BYTE_W-1:0] select_byte(
    input logic [31:0] word,
    input logic [1:0]  idx,
    input logic        lsb_first
  );
    logic [1:0] lane;
    lane = lsb_first ? idx : (2'd3 - idx);
    case (lane)
      2'd0:    select_byte = word[7:0];
      2'd1:    select_byte = word[15:8];
      2'd2:    select_byte = word[23:16];
      default: select_byte = word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/fifo_out_uart_drain.sv
// Purpose : drains FIFO_OUT to the UART TX, one 32-bit word as four bytes.
// Latency : start -> FETCH 2 edges, pop 3 edges, first tx_start 4 edges.
// Backpres: each byte waits on tx_busy (start/busy handshake); FIFO popped
//           only when a word is needed, empty FIFO ends the drain.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        drain request (IDLE only) / synchronous cancel
//   fifo_empty,
//   fifo_rd_data,
//   fifo_rd_en          fall-through FIFO_OUT read port (pop strobe out)
//   tx_busy, tx_start,
//   tx_data             UART TX byte handshake
//   busy, done,
//   word_count          status: active, drained-to-empty pulse, words sent
module fifo_out_uart_drain
  import trng_io_pkg::*;
#(
  parameter bit          LSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_rd_data,
  output logic        fifo_rd_en,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count
);

  // Counter preload: the GAP state is entered for GAP_CYCLES clocks,
  // counting GAP_CYCLES-1 down to 0 inclusive.
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  drain_state_e           state_q, state_d;
  logic                   start_q;
  logic [31:0]            word_q, word_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [7:0]             gap_q, gap_d;
  logic [15:0]            word_count_q, word_count_d;
  logic                   fifo_rd_en_q, fifo_rd_en_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   done_q, done_d;
  logic                   busy_q;
  logic                   advance;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      word_q       <= '0;
      byte_idx_q   <= '0;
      gap_q        <= '0;
      word_count_q <= '0;
      fifo_rd_en_q <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      // The request is registered once before IDLE acts on it; abort in
      // the same cycle kills it so abort always wins over start.
      start_q      <= start & ~abort;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      gap_q        <= gap_d;
      word_count_q <= word_count_d;
      fifo_rd_en_q <= fifo_rd_en_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      done_q       <= done_d;
      // Registered from next state so busy drops together with done.
      busy_q       <= (state_d != S_IDLE);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    gap_d        = gap_q;
    word_count_d = word_count_q;
    fifo_rd_en_d = 1'b0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    done_d       = 1'b0;
    advance      = 1'b0;

    if (abort) begin
      // A popped-but-unfinished word is simply dropped; word_count kept.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_q) begin
            state_d      = S_FETCH;
            word_count_d = '0;
          end
        end

        S_FETCH: begin
          if (fifo_empty) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            word_d       = fifo_rd_data;
            fifo_rd_en_d = 1'b1;
            byte_idx_d   = 2'd0;
            state_d      = S_SEND;
          end
        end

        S_SEND: begin
          if (!tx_busy) begin
            tx_start_d = 1'b1;
            tx_data_d  = select_byte(word_q, byte_idx_q, LSB_FIRST);
            state_d    = S_WAIT_ACK;
          end
        end

        // No timeout here: a TX that never acknowledges is escaped by abort.
        S_WAIT_ACK: begin
          if (tx_busy) begin
            state_d = S_WAIT_DONE;
          end
        end

        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (GAP_CYCLES > 0) begin
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
            end else begin
              advance = 1'b1;
            end
          end
        end

        S_GAP: begin
          if (gap_q == 8'd0) begin
            advance = 1'b1;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase

      // Byte finished: next byte of this word, or next word after the last.
      if (advance) begin
        if (byte_idx_q == 2'd3) begin
          word_count_d = word_count_q + 16'd1;
          state_d      = S_FETCH;
        end else begin
          byte_idx_d = byte_idx_q + 2'd1;
          state_d    = S_SEND;
        end
      end
    end
  end

  assign fifo_rd_en = fifo_rd_en_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_out_uart_drain.sv
// Bench for fifo_out_uart_drain: two instances (0: LSB first, gap 4;
// 1: MSB first, no gap), each with its own FIFO and UART TX model.
// Expected bytes are queued when words are pushed; a monitor pops them.
module tb_fifo_out_uart_drain;

  localparam int BUSY_LEN = 10;
  localparam int GAP_OF [2] = '{4, 0};
  localparam bit LSB_OF [2] = '{1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n_v   = 2'b00;
  logic [1:0]  start_v   = 2'b00;
  logic [1:0]  abort_v   = 2'b00;
  logic [1:0]  txbusy_v  = 2'b00;
  logic [1:0]  empty_v;
  logic [1:0]  rd_en_v;
  logic [1:0]  tx_start_v;
  logic [1:0]  busy_v;
  logic [1:0]  done_v;
  logic [31:0] rd_data [2];
  logic [7:0]  tx_data [2];
  logic [15:0] wc [2];

  // FIFO models (pushed by stimulus, popped by monitor)
  logic [31:0] fmem [2][256];
  int          ftail [2] = '{0, 0};
  int          fhead [2] = '{0, 0};

  // Expected byte stream per instance
  logic [7:0]  exp_mem [2][1024];
  int          et [2] = '{0, 0};
  int          eh [2] = '{0, 0};

  // Monitor / TX model state
  int  cyc = 0;
  int  launched   [2] = '{0, 0};
  bit  in_word    [2] = '{0, 0};
  bit  fall_valid [2] = '{0, 0};
  int  fall_cyc   [2] = '{0, 0};
  bit  prev_rd    [2] = '{0, 0};
  bit  prev_st    [2] = '{0, 0};
  int  full_words [2] = '{0, 0};
  int  done_cnt   [2] = '{0, 0};
  int  launch_cnt [2] = '{0, 0};
  int  rem        [2] = '{0, 0};
  bit  stall      [2] = '{0, 0};

  int tests = 0;
  int fails = 0;

  assign empty_v[0] = (fhead[0] == ftail[0]);
  assign empty_v[1] = (fhead[1] == ftail[1]);
  assign rd_data[0] = fmem[0][fhead[0] % 256];
  assign rd_data[1] = fmem[1][fhead[1] % 256];

  fifo_out_uart_drain #(.LSB_FIRST(1'b1), .GAP_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .fifo_empty(empty_v[0]), .fifo_rd_data(rd_data[0]), .fifo_rd_en(rd_en_v[0]),
    .tx_busy(txbusy_v[0]), .tx_start(tx_start_v[0]), .tx_data(tx_data[0]),
    .busy(busy_v[0]), .done(done_v[0]), .word_count(wc[0])
  );

  fifo_out_uart_drain #(.LSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .fifo_empty(empty_v[1]), .fifo_rd_data(rd_data[1]), .fifo_rd_en(rd_en_v[1]),
    .tx_busy(txbusy_v[1]), .tx_start(tx_start_v[1]), .tx_data(tx_data[1]),
    .busy(busy_v[1]), .done(done_v[1]), .word_count(wc[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor and UART TX model, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n_v[i]) begin
        if (in_word[i] && launched[i] < 4) eh[i] += 4 - launched[i];
        in_word[i]    = 1'b0;
        fall_valid[i] = 1'b0;
        prev_rd[i]    = 1'b0;
        prev_st[i]    = 1'b0;
      end else begin
        if (start_v[i] && !abort_v[i] && !busy_v[i]) begin
          full_words[i] = 0;
          fall_valid[i] = 1'b0;
        end
        if (done_v[i]) begin
          done_cnt[i]++;
          check("done_busy_low", {31'd0, busy_v[i]}, 32'd0);
          check("done_word_count", {16'd0, wc[i]}, full_words[i] & 32'hFFFF);
          check("done_bytes_left", et[i] - eh[i], 32'd0);
        end
        if (rd_en_v[i]) begin
          check("rd_en_one_cycle", {31'd0, prev_rd[i]}, 32'd0);
          check("pop_nonempty", {31'd0, fhead[i] != ftail[i]}, 32'd1);
          if (fhead[i] != ftail[i]) fhead[i]++;
          in_word[i]  = 1'b1;
          launched[i] = 0;
        end
        if (tx_start_v[i]) begin
          check("tx_start_one_cycle", {31'd0, prev_st[i]}, 32'd0);
          if (eh[i] == et[i]) begin
            tests++;
            fails++;
            $display("FAIL unexpected_launch: inst %0d byte 0x%0h, none expected", i, tx_data[i]);
          end else begin
            check("tx_data", {24'd0, tx_data[i]}, {24'd0, exp_mem[i][eh[i]]});
            eh[i]++;
          end
          if (fall_valid[i])
            check("launch_timing", cyc - fall_cyc[i], (launched[i] == 0 ? 3 : 2) + GAP_OF[i]);
          fall_valid[i] = 1'b0;
          launch_cnt[i]++;
          launched[i]++;
          if (launched[i] == 4) begin
            full_words[i]++;
            in_word[i] = 1'b0;
          end
        end
        if (abort_v[i]) begin
          if (in_word[i] && launched[i] < 4) eh[i] += 4 - launched[i];
          in_word[i]    = 1'b0;
          fall_valid[i] = 1'b0;
        end
        prev_rd[i] = rd_en_v[i];
        prev_st[i] = tx_start_v[i];
      end
      // UART TX: accepts a launch, stays busy BUSY_LEN cycles
      if (txbusy_v[i]) begin
        rem[i]--;
        if (rem[i] == 0) begin
          txbusy_v[i]   = 1'b0;
          fall_cyc[i]   = cyc;
          fall_valid[i] = 1'b1;
        end
      end else if (tx_start_v[i] && !stall[i]) begin
        txbusy_v[i] = 1'b1;
        rem[i]      = BUSY_LEN;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input int i, input logic [31:0] w);
    int sh;
    fmem[i][ftail[i] % 256] = w;
    ftail[i]++;
    for (int k = 0; k < 4; k++) begin
      sh = LSB_OF[i] ? 8 * k : 8 * (3 - k);
      exp_mem[i][et[i] + k] = 8'((w >> sh) & 32'hFF);
    end
    et[i] += 4;
  endtask

  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    tick(1);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int k;
    k = 0;
    while (!done_v[i] && k < budget) begin
      tick(1);
      k++;
    end
    check("done_within_budget", {31'd0, done_v[i]}, 32'd1);
    tick(1);
  endtask

  task automatic wait_launches(input int i, input int target, input int budget);
    int k;
    k = 0;
    while (launch_cnt[i] < target && k < budget) begin
      tick(1);
      k++;
    end
    check("launch_reached", {31'd0, launch_cnt[i] >= target}, 32'd1);
  endtask

  initial begin
    int dc, lc, ph, bc;

    tick(3);
    for (int i = 0; i < 2; i++)
      check("reset_outputs", {busy_v[i], done_v[i], rd_en_v[i], tx_start_v[i], tx_data[i], wc[i]}, 32'd0);
    rst_n_v = 2'b11;
    tick(2);

    // Single word, LSB first, with start-to-launch timing
    push_word(0, 32'h11223344);
    dc = done_cnt[0];
    pulse_start(0);
    check("t1_busy_edge0", {31'd0, busy_v[0]}, 32'd0);
    tick(1);
    check("t1_busy_edge1", {31'd0, busy_v[0]}, 32'd1);
    check("t1_rd_en_edge1", {31'd0, rd_en_v[0]}, 32'd0);
    tick(1);
    check("t1_rd_en_edge2", {31'd0, rd_en_v[0]}, 32'd1);
    tick(1);
    check("t1_tx_start_edge3", {31'd0, tx_start_v[0]}, 32'd1);
    check("t1_first_byte", {24'd0, tx_data[0]}, 32'h44);
    wait_done(0, 400);
    check("t1_done_once", done_cnt[0] - dc, 32'd1);
    check("t1_word_count", {16'd0, wc[0]}, 32'd1);

    // Same word, MSB first
    push_word(1, 32'h11223344);
    pulse_start(1);
    wait_done(1, 400);
    check("t2_word_count", {16'd0, wc[1]}, 32'd1);

    // Empty FIFO: done two edges after start sample, nothing sent
    lc = launch_cnt[0];
    ph = fhead[0];
    pulse_start(0);
    tick(1);
    check("t3_busy_edge1", {31'd0, busy_v[0]}, 32'd1);
    check("t3_done_edge1", {31'd0, done_v[0]}, 32'd0);
    tick(1);
    check("t3_done_edge2", {31'd0, done_v[0]}, 32'd1);
    check("t3_busy_edge2", {31'd0, busy_v[0]}, 32'd0);
    check("t3_word_count", {16'd0, wc[0]}, 32'd0);
    tick(2);
    check("t3_no_launch", launch_cnt[0] - lc, 32'd0);
    check("t3_no_pop", fhead[0] - ph, 32'd0);

    // Three random words with the 4-cycle gap
    for (int k = 0; k < 3; k++) push_word(0, $urandom);
    lc = launch_cnt[0];
    dc = done_cnt[0];
    pulse_start(0);
    wait_done(0, 2000);
    tick(2);
    check("t4_launches", launch_cnt[0] - lc, 32'd12);
    check("t4_done_once", done_cnt[0] - dc, 32'd1);
    check("t4_word_count", {16'd0, wc[0]}, 32'd3);

    // Abort during WAIT_DONE of byte 2 of word 2, then resume
    for (int k = 0; k < 4; k++) push_word(1, $urandom);
    lc = launch_cnt[1];
    dc = done_cnt[1];
    pulse_start(1);
    wait_launches(1, lc + 6, 600);
    tick(3);
    abort_v[1] = 1'b1;
    tick(1);
    abort_v[1] = 1'b0;
    check("t5_idle_after_abort", {31'd0, busy_v[1]}, 32'd0);
    tick(20);
    check("t5_no_done", done_cnt[1] - dc, 32'd0);
    check("t5_word_count", {16'd0, wc[1]}, 32'd1);
    pulse_start(1);
    wait_done(1, 2000);
    check("t5_resume_word_count", {16'd0, wc[1]}, 32'd2);

    // start and abort together: stays idle
    push_word(0, 32'h0BADF00D);
    ph = fhead[0];
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    tick(1);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    tick(5);
    check("t6_abort_wins_busy", {31'd0, busy_v[0]}, 32'd0);
    check("t6_abort_wins_pop", fhead[0] - ph, 32'd0);
    pulse_start(0);
    wait_done(0, 1000);
    check("t6_word_count", {16'd0, wc[0]}, 32'd1);

    // Reset while in WAIT_ACK, then no self-start with data present
    push_word(0, 32'hA5B6C7D8);
    push_word(0, 32'h1E2F3A4B);
    stall[0] = 1'b1;
    lc = launch_cnt[0];
    pulse_start(0);
    wait_launches(0, lc + 1, 100);
    tick(3);
    check("t7_busy_before_reset", {31'd0, busy_v[0]}, 32'd1);
    rst_n_v[0] = 1'b0;
    #1;
    check("t7_reset_outputs", {busy_v[0], done_v[0], rd_en_v[0], tx_start_v[0], tx_data[0], wc[0]}, 32'd0);
    tick(2);
    stall[0] = 1'b0;
    rst_n_v[0] = 1'b1;
    bc = 0;
    repeat (20) begin
      tick(1);
      if (busy_v[0] || rd_en_v[0]) bc++;
    end
    check("t7_stays_idle", bc, 32'd0);
    pulse_start(0);
    wait_done(0, 1000);
    check("t7_word_count", {16'd0, wc[0]}, 32'd1);

    // Random rounds on both instances
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2; i++) begin
        int n;
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) push_word(i, $urandom);
        pulse_start(i);
        wait_done(i, 2000);
        check("rand_word_count", {16'd0, wc[i]}, n);
      end
    end

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
